// File: rtl/stream_demux_if.sv
// Handshake bundle for stream_demux: one upstream valid/ready port fanned out to N channels.
// The in_bcast signal exists only when STREAM_DEMUX_BCAST_EN is defined.
interface stream_demux_if #(
    parameter int WIDTH = 8,
    parameter int N     = 8
);
    localparam int SEL_W = $clog2(N);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic [SEL_W-1:0]     in_sel;
    logic [N-1:0]         out_valid;
    logic [N-1:0]         out_ready;
    logic [N*WIDTH-1:0]   out_data;
    logic [7:0]           drop_cnt;
`ifdef STREAM_DEMUX_BCAST_EN
    logic                 in_bcast;

    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data, drop_cnt
    );

    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data, drop_cnt
    );
`else
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, drop_cnt
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, drop_cnt
    );
`endif
endinterface

// File: rtl/stream_demux.sv
// One-word holding stage that routes each accepted word to one output channel (or all of them
// when STREAM_DEMUX_BCAST_EN is defined), counting words dropped for an out-of-range select.
module stream_demux #(
    parameter int WIDTH = 8,
    parameter int N     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    stream_demux_if.slave bus
);
    localparam int               SEL_W = $clog2(N);
    localparam logic [SEL_W:0]   N_LIM = (SEL_W+1)'(N);

    logic [WIDTH-1:0] hold_r;
    logic [N-1:0]     pend_r;
    logic [7:0]       drop_r;

    logic             in_ready_s;
    logic             accept_s;
    logic             bcast_s;
    logic             in_range_s;
    logic             load_s;
    logic             drop_s;
    logic [N-1:0]     pend_nxt_s;

    function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N-1:0] v;
        v = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            v[i] = (idx == SEL_W'(i));
        end
        return v;
    endfunction

    // Handshake decode and next pending mask; in_ready never looks at in_valid.
    always_comb begin
        in_ready_s = ((pend_r & ~bus.out_ready) == {N{1'b0}});
        accept_s   = bus.in_valid & in_ready_s;
`ifdef STREAM_DEMUX_BCAST_EN
        bcast_s    = bus.in_bcast;
`else
        bcast_s    = 1'b0;
`endif
        in_range_s = ({1'b0, bus.in_sel} < N_LIM);
        load_s     = accept_s & (bcast_s | in_range_s);
        drop_s     = accept_s & ~bcast_s & ~in_range_s;
        if (accept_s) begin
            if (bcast_s) begin
                pend_nxt_s = {N{1'b1}};
            end else if (in_range_s) begin
                pend_nxt_s = onehot(bus.in_sel);
            end else begin
                // Every still-pending channel completes on an accepting edge.
                pend_nxt_s = {N{1'b0}};
            end
        end else begin
            pend_nxt_s = pend_r & ~bus.out_ready;
        end
    end

    // Holding-stage state and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_r <= {WIDTH{1'b0}};
            pend_r <= {N{1'b0}};
            drop_r <= 8'd0;
        end else begin
            pend_r <= pend_nxt_s;
            if (load_s) begin
                hold_r <= bus.in_data;
            end else begin
                hold_r <= hold_r;
            end
            if (drop_s && (drop_r != 8'hFF)) begin
                drop_r <= drop_r + 8'd1;
            end else begin
                drop_r <= drop_r;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = pend_r;
    assign bus.out_data  = {N{hold_r}};
    assign bus.drop_cnt  = drop_r;
endmodule

// File: tb/tb_stream_demux.sv
// Randomized bench for stream_demux: a per-cycle compare against a queue-based scoreboard on an
// N=8 instance, plus directed reset/back-to-back/backpressure/drop (N=6) and broadcast scenarios.
module tb_stream_demux;
    logic clk;
    logic rst_n;

    stream_demux_if #(.WIDTH(8), .N(8)) b8 ();
    stream_demux_if #(.WIDTH(8), .N(6)) b6 ();

    stream_demux #(.WIDTH(8), .N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    stream_demux #(.WIDTH(8), .N(6)) dut6 (.clk(clk), .rst_n(rst_n), .bus(b6));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: outstanding (channel, word) deliveries, last word held, drops seen.
    typedef struct {
        int         ch;
        logic [7:0] d;
    } ent_t;

    ent_t       sb[$];
    logic [7:0] last_word;
    int         drops;

    function automatic logic [7:0] exp_mask();
        logic [7:0] m;
        m = 8'h00;
        foreach (sb[i]) m[sb[i].ch] = 1'b1;
        return m;
    endfunction

    initial begin
        sb.delete();
        last_word = 8'h00;
        drops     = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                sb.delete();
                last_word = 8'h00;
                drops     = 0;
            end else begin
                logic [7:0] m;
                logic       rdy;
                logic       bc;
                m   = exp_mask();
                rdy = ((m & ~b8.out_ready) == 8'h00);
                for (int c = 0; c < 8; c++) begin
                    if (m[c] && b8.out_ready[c]) begin
                        for (int i = 0; i < sb.size(); i++) begin
                            if (sb[i].ch == c) begin
                                sb.delete(i);
                                break;
                            end
                        end
                    end
                end
`ifdef STREAM_DEMUX_BCAST_EN
                bc = b8.in_bcast;
`else
                bc = 1'b0;
`endif
                if (b8.in_valid && rdy) begin
                    if (bc) begin
                        for (int c = 0; c < 8; c++) sb.push_back('{c, b8.in_data});
                        last_word = b8.in_data;
                    end else if (int'(b8.in_sel) < 8) begin
                        sb.push_back('{int'(b8.in_sel), b8.in_data});
                        last_word = b8.in_data;
                    end else begin
                        if (drops < 255) drops++;
                    end
                end
            end
        end
    end

    // Compare process for the N=8 instance, away from the active edge.
    initial begin
        forever begin
            logic [7:0] m;
            @(negedge clk);
            m = exp_mask();
            chk("out_valid", 64'(b8.out_valid), 64'(m));
            chk("in_ready", 64'(b8.in_ready), 64'((m & ~b8.out_ready) == 8'h00));
            chk("out_data", b8.out_data, {8{last_word}});
            chk("drop_cnt", 64'(b8.drop_cnt), 64'(drops));
        end
    end

    initial begin
        logic [7:0] exp_v;
        rst_n        = 1'b0;
        b8.in_valid  = 1'b0;
        b8.in_sel    = 3'd0;
        b8.in_data   = 8'h00;
        b8.out_ready = 8'h00;
        b6.in_valid  = 1'b0;
        b6.in_sel    = 3'd0;
        b6.in_data   = 8'h00;
        b6.out_ready = 6'h00;
`ifdef STREAM_DEMUX_BCAST_EN
        b8.in_bcast  = 1'b0;
        b6.in_bcast  = 1'b0;
`endif
        #2;
        chk("rst_out_valid", 64'(b8.out_valid), 64'h0);
        chk("rst_in_ready", 64'(b8.in_ready), 64'h1);
        tick();
        tick();
        rst_n = 1'b1;

        // Reset while a word is pending on channel 4.
        b8.out_ready = 8'hEF;
        b8.in_valid  = 1'b1;
        b8.in_sel    = 3'd4;
        b8.in_data   = 8'h42;
        tick();
        b8.in_valid = 1'b0;
        #1;
        chk("pre_rst_valid", 64'(b8.out_valid), 64'h10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(b8.out_valid), 64'h00);
        chk("mid_rst_drop", 64'(b8.drop_cnt), 64'h00);
        chk("mid_rst_ready", 64'(b8.in_ready), 64'h1);
        tick();
        rst_n        = 1'b1;
        b8.out_ready = 8'h00;
        b8.in_valid  = 1'b1;
        b8.in_sel    = 3'd2;
        b8.in_data   = 8'h99;
        tick();
        #1;
        chk("first_accept", 64'(b8.out_valid), 64'h04);
        chk("first_data", 64'(b8.out_data[23:16]), 64'h99);

        // Back-to-back across all channels.
        b8.out_ready = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            b8.in_valid = 1'b1;
            b8.in_sel   = 3'(k);
            b8.in_data  = 8'hA0 + 8'(k);
            tick();
            #1;
            chk("b2b_valid", 64'(b8.out_valid), 64'(8'h01 << k));
            chk("b2b_data", 64'(b8.out_data[k*8 +: 8]), 64'(8'hA0 + 8'(k)));
            chk("b2b_ready", 64'(b8.in_ready), 64'h1);
        end
        b8.in_valid = 1'b0;
        tick();

        // Backpressure on channel 3 with a second word waiting.
        b8.out_ready = 8'hF7;
        b8.in_valid  = 1'b1;
        b8.in_sel    = 3'd3;
        b8.in_data   = 8'h5C;
        tick();
        b8.in_sel  = 3'd5;
        b8.in_data = 8'h6D;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_valid", 64'(b8.out_valid), 64'h08);
            chk("bp_ready", 64'(b8.in_ready), 64'h0);
            chk("bp_data", 64'(b8.out_data[31:24]), 64'h5C);
            tick();
        end
        b8.out_ready = 8'hFF;
        #1;
        chk("bp_release_ready", 64'(b8.in_ready), 64'h1);
        tick();
        #1;
        chk("bp_next_valid", 64'(b8.out_valid), 64'h20);
        chk("bp_next_data", 64'(b8.out_data[47:40]), 64'h6D);
        b8.in_valid = 1'b0;
        tick();

        // Drop saturation on the N=6 instance; held word must survive the drops.
        b6.out_ready = 6'h3F;
        b6.in_valid  = 1'b1;
        b6.in_sel    = 3'd0;
        b6.in_data   = 8'h77;
        tick();
        #1;
        chk("n6_unicast", 64'(b6.out_valid), 64'h01);
        for (int k = 1; k <= 300; k++) begin
            b6.in_sel  = (k % 2 == 1) ? 3'd6 : 3'd7;
            b6.in_data = 8'($urandom);
            tick();
            #1;
            chk("n6_drop_cnt", 64'(b6.drop_cnt), 64'((k > 255) ? 255 : k));
            chk("n6_valid", 64'(b6.out_valid), 64'h00);
            chk("n6_hold", 64'(b6.out_data), 64'({6{8'h77}}));
            chk("n6_ready", 64'(b6.in_ready), 64'h1);
        end
        b6.in_valid = 1'b0;
        tick();

`ifdef STREAM_DEMUX_BCAST_EN
        // Broadcast drained one channel per cycle.
        b8.out_ready = 8'h00;
        b8.in_valid  = 1'b1;
        b8.in_bcast  = 1'b1;
        b8.in_sel    = 3'd5;
        b8.in_data   = 8'h3E;
        tick();
        b8.in_valid = 1'b0;
        b8.in_bcast = 1'b0;
        #1;
        chk("bc_valid", 64'(b8.out_valid), 64'hFF);
        for (int c = 0; c < 8; c++) begin
            b8.out_ready = 8'h01 << c;
            #1;
            chk("bc_ready", 64'(b8.in_ready), 64'(c == 7));
            tick();
            #1;
            exp_v = 8'hFE << c;
            chk("bc_drain", 64'(b8.out_valid), 64'(exp_v));
            chk("bc_drop", 64'(b8.drop_cnt), 64'h00);
        end
`endif

        // Random traffic with occasional mid-run reset.
        for (int c = 0; c < 3000; c++) begin
            b8.in_valid  = 1'($urandom_range(0, 1));
            b8.in_sel    = 3'($urandom_range(0, 7));
            b8.in_data   = 8'($urandom);
            b8.out_ready = 8'($urandom | $urandom);
`ifdef STREAM_DEMUX_BCAST_EN
            b8.in_bcast  = ($urandom_range(0, 7) == 0);
`endif
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_n       = 1'b1;
        b8.in_valid = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, minimum 1.
REQ-002 Parameter N, default 8: output channel count, range 2..64.
REQ-003 Parameter SEL_W, default $clog2(N): select width, derived from N and never overridden.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1: reset, asynchronous, active-low.
REQ-006 in_valid  input  1: upstream word present.
REQ-007 in_ready  output  1: block accepts the word this cycle.
REQ-008 in_data  input  WIDTH: upstream word.
REQ-009 in_sel  input  SEL_W: destination channel index.
REQ-010 out_valid  output  N: bit i set means channel i holds a word.
REQ-011 out_ready  input  N: bit i set means channel i consumer accepts.
REQ-012 out_data  output  N*WIDTH: slice i is bits [i*WIDTH +: WIDTH]; all slices carry the same held word.
REQ-013 drop_cnt  output  8: count of words discarded for an out-of-range select.

Function
REQ-014 Holding stage: one data register hold_q (WIDTH bits) plus a pending mask pend_q (N bits).
REQ-015 out_valid equals pend_q; every out_data slice equals hold_q.
REQ-016 Channel i transfer occurs when pend_q[i] and out_ready[i] are both 1; pend_q[i] clears on that edge.
REQ-017 in_ready = ((pend_q & ~out_ready) == 0): high when the stage is empty or every pending channel completes this cycle.
REQ-018 Input accept occurs when in_valid and in_ready are both 1.
REQ-019 Unicast accept with in_sel < N: hold_q <= in_data and pend_q <= one-hot(in_sel) on the same edge.
REQ-020 Accept in the same cycle as the final pending transfer: the new word replaces the old one, giving one word per cycle sustained throughput with no bubble.
REQ-021 Latency: an accepted word appears on out_valid one cycle after acceptance.
REQ-022 Out-of-range accept with in_sel >= N (possible only when N is not a power of 2): the word is consumed.
REQ-023 On an out-of-range accept, pend_q <= 0 unless a new pending mask is loaded, hold_q is unchanged, and drop_cnt increments, saturating at 255.
REQ-024 No accept and no transfer: hold_q and pend_q hold their values.
REQ-025 in_data and in_sel are ignored when in_valid is 0.
REQ-026 out_ready bits for non-pending channels are ignored.
REQ-027 Upstream may drop in_valid without a handshake; no word is latched in that case.
REQ-028 in_ready is combinational from pend_q and out_ready only, never from in_valid, so no combinational loop through upstream exists.

Reset
REQ-029 rst_n low asynchronously forces pend_q=0, hold_q=0 and drop_cnt=0; out_valid is therefore 0.
REQ-030 in_ready is 1 during and immediately after reset.
REQ-031 Reset asserted mid-operation discards any pending word with no partial delivery afterwards.
REQ-032 The first accept can occur on the first rising edge after rst_n deasserts.

Configuration
REQ-033 Macro STREAM_DEMUX_BCAST_EN defined: input port in_bcast (1 bit) exists.
REQ-034 With the macro defined, an accept with in_bcast=1 loads pend_q with all N bits set regardless of in_sel and never counts a drop.
REQ-035 With the macro defined, each channel drains a broadcast word independently; in_ready follows REQ-017 unchanged.
REQ-036 Macro STREAM_DEMUX_BCAST_EN undefined: port in_bcast is absent and every accept is unicast or dropped per REQ-019 and REQ-022.

Verification
REQ-037 Reset test: N=8, assert rst_n low with pend_q=8'h10 -> out_valid=0, drop_cnt=0 and in_ready=1 within the same cycle.
REQ-038 Back-to-back test: N=8, all out_ready=1, in_sel=0..7 over 8 consecutive cycles with data 8'hA0..8'hA7 -> out_valid one-hot bit k carries 8'hA0+k one cycle later; in_ready stays 1 throughout.
REQ-039 Backpressure test: in_sel=3, data 8'h5C, out_ready[3]=0 for 4 cycles -> out_valid=8'h08 held, in_ready=0, second word not latched; raising out_ready[3] releases the word and accepts the next word on that same edge.
REQ-040 Drop test: N=6, in_sel=6 and 7 accepted 300 times -> out_valid stays 0 and drop_cnt saturates at 255.
REQ-041 Broadcast test (STREAM_DEMUX_BCAST_EN defined): in_bcast=1, data 8'h3E, out_ready raised one channel per cycle from 0 to 7 -> pend_q clears bit by bit, in_ready rises in the cycle channel 7 is ready, drop_cnt unchanged.
REQ-042 Random test: random in_valid, in_sel, out_ready and mid-run reset against a scoreboard -> every word delivered exactly once to its channel, in order, and no delivery after reset.
